// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types for the side-lane sensor qualifier and the
//               traffic signal controller (lane FSM states, signal codes).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLD    = 2'd2,
        LOCKOUT = 2'd3
    } lane_state_t;

    typedef enum logic [1:0] {
        SIG_GREEN  = 2'b01,
        SIG_YELLOW = 2'b10,
        SIG_RED    = 2'b11
    } signal_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser and stability counter for the raw loop
//               detector; det follows the input after DEB_CYCLES stable cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic det
);

    localparam int c_dcnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic                s1_q;
    logic                s2_q;
    logic                det_q;
    logic                det_d;
    logic [c_dcnt_w-1:0] dcnt_q;
    logic [c_dcnt_w-1:0] dcnt_d;

    always_comb begin
        det_d  = det_q;
        dcnt_d = '0;
        if (s2_q != det_q) begin
            if (dcnt_q == c_dcnt_w'(DEB_CYCLES - 1)) begin
                det_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            det_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            det_q  <= det_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign det = det_q;

endmodule
`default_nettype wire

// File: rtl/lane_sensor_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : lane_sensor_qualifier
// Description : Debounced, hold-stretched side-lane demand with arrival count.
//               Optional demand cap / lockout enabled by SENSOR_DEMAND_CAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_sensor_qualifier
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int DEB_CYCLES = 3,
    parameter int HOLD_TICKS = 2,
    parameter int MAX_TICKS  = 20,
    parameter int LOCK_TICKS = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_sensor,
    output logic             sensor,
    output logic [CNT_W-1:0] arrivals,
    output logic             cap_pulse
);

    localparam int c_tick_max = max_int(HOLD_TICKS, max_int(MAX_TICKS, LOCK_TICKS));
    localparam int c_tmr_w    = $clog2(c_tick_max) + 1;
    localparam int c_pcnt_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic                det;
    logic                tick;
    logic [c_pcnt_w-1:0] pcnt_q, pcnt_d;
    lane_state_t         state_q, state_d;
    logic [c_tmr_w-1:0]  htmr_q, htmr_d;
    logic                sensor_q, sensor_d;
    logic [CNT_W-1:0]    arrivals_q, arrivals_d;

    sensor_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk(clk),
        .rst(rst),
        .raw(raw_sensor),
        .det(det)
    );

    assign tick = (pcnt_q == c_pcnt_w'(TICK_DIV - 1));

`ifdef SENSOR_DEMAND_CAP_EN
    logic [c_tmr_w-1:0] atmr_q, atmr_d;
    logic [c_tmr_w-1:0] ltmr_q, ltmr_d;
    logic               cap_pulse_q, cap_pulse_d;
    logic               cap_hit;

    assign cap_hit = tick && (atmr_q == c_tmr_w'(MAX_TICKS - 1));
`endif

    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
        state_d    = state_q;
        htmr_d     = htmr_q;
        arrivals_d = arrivals_q;
`ifdef SENSOR_DEMAND_CAP_EN
        atmr_d      = atmr_q;
        ltmr_d      = ltmr_q;
        cap_pulse_d = 1'b0;
        // Demand-time counts through ACTIVE and HOLD so a flickering loop cannot reset the cap.
        if ((state_q == ACTIVE || state_q == HOLD) && tick && atmr_q != '1)
            atmr_d = atmr_q + 1'b1;
        if (state_q == LOCKOUT && tick && ltmr_q != '1)
            ltmr_d = ltmr_q + 1'b1;
`endif
        if (state_q == HOLD && tick && htmr_q != '1)
            htmr_d = htmr_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (det) begin
                    state_d = ACTIVE;
                    if (arrivals_q != {CNT_W{1'b1}})
                        arrivals_d = arrivals_q + 1'b1;
`ifdef SENSOR_DEMAND_CAP_EN
                    atmr_d = '0;
`endif
                end
            end
            ACTIVE: begin
                if (!det) begin
                    state_d = HOLD;
                    htmr_d  = '0;
                end
`ifdef SENSOR_DEMAND_CAP_EN
                else if (cap_hit) begin
                    state_d     = LOCKOUT;
                    ltmr_d      = '0;
                    cap_pulse_d = 1'b1;
                end
`endif
            end
            HOLD: begin
`ifdef SENSOR_DEMAND_CAP_EN
                if (cap_hit) begin
                    state_d     = LOCKOUT;
                    ltmr_d      = '0;
                    cap_pulse_d = 1'b1;
                end else
`endif
                if (det)
                    state_d = ACTIVE;
                else if (tick && htmr_q == c_tmr_w'(HOLD_TICKS - 1))
                    state_d = IDLE;
            end
`ifdef SENSOR_DEMAND_CAP_EN
            LOCKOUT: begin
                if (tick && ltmr_q == c_tmr_w'(LOCK_TICKS - 1))
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        sensor_d = (state_d == ACTIVE) || (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q     <= '0;
            state_q    <= IDLE;
            htmr_q     <= '0;
            sensor_q   <= 1'b0;
            arrivals_q <= '0;
        end else begin
            pcnt_q     <= pcnt_d;
            state_q    <= state_d;
            htmr_q     <= htmr_d;
            sensor_q   <= sensor_d;
            arrivals_q <= arrivals_d;
        end
    end

`ifdef SENSOR_DEMAND_CAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            atmr_q      <= '0;
            ltmr_q      <= '0;
            cap_pulse_q <= 1'b0;
        end else begin
            atmr_q      <= atmr_d;
            ltmr_q      <= ltmr_d;
            cap_pulse_q <= cap_pulse_d;
        end
    end

    assign cap_pulse = cap_pulse_q;
`else
    assign cap_pulse = 1'b0;
`endif

    assign sensor   = sensor_q;
    assign arrivals = arrivals_q;

endmodule
`default_nettype wire
